// File: rtl/alu_pkg.sv
// Shared ALU issue-path types: operation codes, RV32I opcodes, issue bundle
// layout and the skid-buffer state encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SLL  = 4'h3,
    ALU_SLT  = 4'h4,
    ALU_SLTU = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_OR   = 4'h9,
    ALU_AND  = 4'hA
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ALT = 7'h20;

  typedef struct packed {
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    alu_op_e           alu_ctrl;
    logic [4:0]        rd_addr;
    logic              is_branch;
    logic              br_invert;
    logic              illegal;
  } issue_bundle_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Base funct3 mapping shared by register and immediate ALU forms
  function automatic alu_op_e f3_base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered in_ready/out_valid; strict FIFO order,
// output held stable while stalled.
module pipe_skid_buf
  import alu_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state;
  T            out_q;
  T            skid_q;

  logic acc;
  logic drn;

  assign acc      = in_valid && in_ready;
  assign drn      = out_valid && out_ready;
  assign out_data = out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SKID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (acc) begin
            out_q     <= in_data;
            out_valid <= 1'b1;
            state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (acc && !drn) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= SKID_FULL;
          end else if (acc && drn) begin
            out_q <= in_data;
          end else if (drn) begin
            out_valid <= 1'b0;
            state     <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (drn) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into an ALU issue bundle
// and hands it to execute through a 2-entry skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1,
  output logic [DATA_WIDTH-1:0] out_rs2,
  output logic [3:0]            out_alu_ctrl,
  output logic [4:0]            out_rd_addr,
  output logic                  out_is_branch,
  output logic                  out_br_invert,
  output logic                  out_illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  issue_bundle_t dec;
  issue_bundle_t q;
  logic          ill;

  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    dec.rs1      = in_rs1_val;
    dec.rs2      = in_rs2_val;
    dec.rd_addr  = in_instr[11:7];
    dec.alu_ctrl = ALU_NOP;
    case (opc)
      OP_R: begin
        if (f7 == 7'h00)
          dec.alu_ctrl = f3_base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)
          dec.alu_ctrl = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          dec.alu_ctrl = ALU_SRA;
        else
          ill = 1'b1;
      end
      OP_IMM: begin
        dec.rs2 = imm_i;
        if (f3 == 3'b001) begin
          // Shift-immediates carry the shift amount, not the raw imm field
          dec.rs2 = shamt;
          if (f7 == 7'h00) dec.alu_ctrl = ALU_SLL;
          else             ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.rs2 = shamt;
          if (f7 == 7'h00)       dec.alu_ctrl = ALU_SRL;
          else if (f7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
          else                   ill = 1'b1;
        end else begin
          dec.alu_ctrl = f3_base_op(f3);
        end
      end
      OP_LOAD: begin
        dec.alu_ctrl = ALU_ADD;
        dec.rs2      = imm_i;
      end
      OP_STORE: begin
        dec.alu_ctrl = ALU_ADD;
        dec.rs2      = imm_s;
        dec.rd_addr  = 5'd0;
      end
      OP_LUI: begin
        dec.alu_ctrl = ALU_ADD;
        dec.rs1      = '0;
        dec.rs2      = imm_u;
      end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.rd_addr   = 5'd0;
        dec.br_invert = f3[0];
        case (f3)
          3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: dec.alu_ctrl = ALU_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings still issue so execute can trap in order
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---- issue register / skid buffer boundary ----
  pipe_skid_buf #(
    .T(issue_bundle_t)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );

  assign out_rs1       = q.rs1;
  assign out_rs2       = q.rs2;
  assign out_alu_ctrl  = q.alu_ctrl;
  assign out_rd_addr   = q.rd_addr;
  assign out_is_branch = q.is_branch;
  assign out_br_invert = q.br_invert;
  assign out_illegal   = q.illegal;

endmodule
